// File: rtl/lieat_exu_alu_dpath.sv
// Shared integer ALU datapath with one-hot op select and a registered, backpressured result stage.
// Define ALU_SHIFT_SERIAL_EN to replace the barrel shifter with a one-bit-per-cycle serial shifter.
module lieat_exu_alu_dpath #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            alu_req,
  output logic            alu_req_ready,
  input  logic [XLEN-1:0] alu_req_op1,
  input  logic [XLEN-1:0] alu_req_op2,
  input  logic            alu_req_add,
  input  logic            alu_req_sub,
  input  logic            alu_req_xor,
  input  logic            alu_req_sll,
  input  logic            alu_req_srl,
  input  logic            alu_req_sra,
  input  logic            alu_req_or,
  input  logic            alu_req_and,
  input  logic            alu_req_slt,
  input  logic            alu_req_sltu,
  input  logic            alu_req_lui,
  output logic            alu_res_valid,
  input  logic            alu_res_ready,
  output logic [XLEN-1:0] alu_req_res
);

  logic            accept;
  logic            consume;
  logic [SHW-1:0]  shamt;
  logic            lt_u;
  logic            lt_s;
  logic [XLEN-1:0] misc_res;

  assign accept  = alu_req && alu_req_ready;
  assign consume = alu_res_valid && alu_res_ready;
  assign shamt   = alu_req_op2[SHW-1:0];

  // Signed compare reuses the unsigned one: differing signs decide by op1's sign.
  assign lt_u = alu_req_op1 < alu_req_op2;
  assign lt_s = (alu_req_op1[XLEN-1] != alu_req_op2[XLEN-1]) ? alu_req_op1[XLEN-1] : lt_u;

  // Every non-shift op, OR-combined so that multi-flag requests merge their results.
  always_comb begin
    // NOTE: the default assignment first guarantees no latch for flags left unselected.
    misc_res = '0;
    if (alu_req_add)  misc_res = misc_res | (alu_req_op1 + alu_req_op2);
    if (alu_req_sub)  misc_res = misc_res | (alu_req_op1 - alu_req_op2);
    if (alu_req_xor)  misc_res = misc_res | (alu_req_op1 ^ alu_req_op2);
    if (alu_req_or)   misc_res = misc_res | (alu_req_op1 | alu_req_op2);
    if (alu_req_and)  misc_res = misc_res | (alu_req_op1 & alu_req_op2);
    if (alu_req_slt)  misc_res = misc_res | {{(XLEN-1){1'b0}}, lt_s};
    if (alu_req_sltu) misc_res = misc_res | {{(XLEN-1){1'b0}}, lt_u};
    if (alu_req_lui)  misc_res = misc_res | alu_req_op2;
  end

`ifdef ALU_SHIFT_SERIAL_EN

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] w_sll;
  logic [XLEN-1:0] w_srl;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] rest;
  logic            f_sll;
  logic            f_srl;
  logic            f_sra;
  logic            is_shift;
  logic            go_serial;
  logic [XLEN-1:0] imm_res;
  logic [XLEN-1:0] nxt_sll;
  logic [XLEN-1:0] nxt_srl;
  logic [XLEN-1:0] nxt_sra;
  logic [XLEN-1:0] fin_res;

  assign alu_req_ready = (state == IDLE) && (!alu_res_valid || alu_res_ready);

  assign is_shift  = alu_req_sll || alu_req_srl || alu_req_sra;
  assign go_serial = accept && is_shift && (shamt != '0);

  // A zero shift amount of any kind yields op1 unchanged.
  assign imm_res = misc_res | (is_shift ? alu_req_op1 : '0);

  assign nxt_sll = {w_sll[XLEN-2:0], 1'b0};
  assign nxt_srl = {1'b0, w_srl[XLEN-1:1]};
  assign nxt_sra = {w_sra[XLEN-1], w_sra[XLEN-1:1]};

  // Final-step result: the last shift happens in the same edge that loads the output.
  assign fin_res = rest
                 | (f_sll ? nxt_sll : '0)
                 | (f_srl ? nxt_srl : '0)
                 | (f_sra ? nxt_sra : '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      alu_res_valid <= 1'b0;
      alu_req_res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_serial) begin
            state         <= SHIFT;
            cnt           <= shamt;
            alu_res_valid <= 1'b0;
          end else if (accept) begin
            alu_req_res   <= imm_res;
            alu_res_valid <= 1'b1;
          end else if (consume) begin
            alu_res_valid <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            alu_req_res   <= fin_res;
            alu_res_valid <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded before they are read.
  always_ff @(posedge clk) begin
    if (go_serial) begin
      w_sll <= alu_req_op1;
      w_srl <= alu_req_op1;
      w_sra <= alu_req_op1;
      rest  <= misc_res;
      f_sll <= alu_req_sll;
      f_srl <= alu_req_srl;
      f_sra <= alu_req_sra;
    end else if (state == SHIFT) begin
      w_sll <= nxt_sll;
      w_srl <= nxt_srl;
      w_sra <= nxt_sra;
    end
  end

`else

  logic [XLEN-1:0] sll_res;
  logic [XLEN-1:0] srl_res;
  logic [XLEN-1:0] sra_res;
  logic [XLEN-1:0] comb_res;

  assign alu_req_ready = !alu_res_valid || alu_res_ready;

  assign sll_res = alu_req_op1 << shamt;
  assign srl_res = alu_req_op1 >> shamt;
  assign sra_res = $unsigned($signed(alu_req_op1) >>> shamt);

  assign comb_res = misc_res
                  | (alu_req_sll ? sll_res : '0)
                  | (alu_req_srl ? srl_res : '0)
                  | (alu_req_sra ? sra_res : '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      alu_res_valid <= 1'b0;
      alu_req_res   <= '0;
    end else if (accept) begin
      alu_req_res   <= comb_res;
      alu_res_valid <= 1'b1;
    end else if (consume) begin
      alu_res_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: doc/lieat_exu_alu_dpath.md
# lieat_exu_alu_dpath

Shared integer ALU datapath: the responder side of the `alu_req_*` interface driven by the EXU common ALU dispatch. It accepts one operation per handshake (operands plus one-hot op flags), computes the result, and holds it in a registered output stage with its own valid/ready handshake toward writeback. An optional bit-serial shifter trades shift latency for area.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two, at least 8.
- `SHW`, `$clog2(XLEN)`: shift-amount width (derived; do not override).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `alu_req`  in  1  request valid.
- `alu_req_ready`  out  1  datapath can accept a request this cycle.
- `alu_req_op1`  in  XLEN  operand 1.
- `alu_req_op2`  in  XLEN  operand 2; also the shift amount and the LUI value.
- `alu_req_add` / `_sub` / `_xor` / `_sll` / `_srl` / `_sra` / `_or` / `_and` / `_slt` / `_sltu` / `_lui`  in  1 each  one-hot op select.
- `alu_res_valid`  out  1  `alu_req_res` holds a completed result.
- `alu_res_ready`  in  1  consumer takes the result.
- `alu_req_res`  out  XLEN  registered result.

## Operation
- Accept when `alu_req && alu_req_ready`. Operands and flags are sampled only at acceptance.
- Results, mod 2^XLEN:
  - add: op1+op2.
  - sub: op1−op2.
  - xor / or / and: bitwise.
  - sll / srl: logical shift of op1 by `op2[SHW-1:0]`.
  - sra: arithmetic shift with sign fill from `op1[XLEN-1]`.
  - slt: signed op1<op2 → 1, else 0, zero-extended.
  - sltu: unsigned compare, same encoding.
  - lui: op2 passed through.
- Flags all zero → result 0. Multiple flags set → bitwise OR of each selected op's result. No error is raised in either case.
- `alu_req_ready = (state==IDLE) && (!alu_res_valid || alu_res_ready)`. An accepted request can therefore replace a result in the same cycle it is consumed.
- Result register: loaded on completion and held stable while `alu_res_valid && !alu_res_ready`. `alu_res_valid` clears on consume unless a new result completes in the same cycle.
- States: IDLE, SHIFT. SHIFT exists only with `ALU_SHIFT_SERIAL_EN`; without it the block has no FSM beyond the output stage.

## Timing
- Reset (`rstn` low at an edge): `alu_res_valid`=0, `alu_req_res`=0, state=IDLE, shift counter=0. `alu_req_ready` is 1 from the first cycle after reset. Reset during SHIFT abandons the operation and produces no result.
- Non-serial ops: accept at edge N, `alu_res_valid`=1 after edge N (latency 1). Back-to-back throughput is 1 per cycle when `alu_res_ready`=1.
- Backpressure: while `alu_res_valid && !alu_res_ready`, `alu_req_ready`=0 and `alu_req_res` is unchanged.

## Configuration
- `ALU_SHIFT_SERIAL_EN` undefined: sll/srl/sra use a barrel shifter with latency 1, like every other op.
- `ALU_SHIFT_SERIAL_EN` defined: shifts are bit-serial.
  - At acceptance (edge N), with shamt k = `op2[SHW-1:0]`: if k=0, op1 is written to the result register at edge N (latency 1). Otherwise enter SHIFT with work=op1 and cnt=k.
  - Each SHIFT edge shifts work by 1 bit in the selected direction/fill and decrements cnt.
  - The edge where cnt goes 1→0 writes the result, sets `alu_res_valid`, and returns to IDLE. Result is valid after edge N+k; latency is max(1,k), worst case XLEN−1.
  - `alu_req_ready`=0 throughout SHIFT.
  - Multi-flag OR combining that includes a shift uses the serial shift result, written at completion.

## Test plan
- Reset with `alu_req`=1 held → `alu_res_valid`=0 and `alu_req_res`=0 during reset; `alu_req_ready`=1 on the first cycle after `rstn` rises.
- add 0xFFFFFFFF+1 → 0x0; sub 0−1 → 0xFFFFFFFF; slt 0x80000000 vs 1 → 1; sltu same operands → 0; lui op2=0x12345000 → 0x12345000. Each appears one cycle after acceptance.
- sra 0x80000000 by op2=0x3F (shamt 31) → 0xFFFFFFFF; srl same → 0x1. With `ALU_SHIFT_SERIAL_EN`: valid exactly 31 cycles after acceptance and `alu_req_ready`=0 throughout; shamt 0 gives valid after 1 cycle with result op1.
- Backpressure: 3 back-to-back adds with `alu_res_ready`=0 for 4 cycles → first result held stable, `alu_req_ready`=0, no result lost or duplicated after release.
- Consume-and-accept: `alu_res_ready`=1 and a new `alu_req` in the same cycle → new result valid next cycle, `alu_res_valid` never drops.
- Flags all zero → 0. xor+and on 0xF0F0,0xFF00 → 0xFFF0. Reset asserted mid-SHIFT → no `alu_res_valid` pulse afterward.
